// File: rtl/mem_dump_tx_if.sv
// Signal bundle between the memory-dump serializer and its surroundings:
// the dump request/ready handshake, the memory read bus and the serial line.
interface mem_dump_tx_if;
  logic       soc;
  logic       eoc;
  logic [9:0] base;
  logic [7:0] num;
  logic [9:0] a9_a0;
  logic [7:0] d7_d0;
  logic       mr_;
  logic       txd;

  // The master requests dumps and owns the memory data; the slave is the serializer.
  modport master (
    output soc, base, num, d7_d0,
    input  eoc, a9_a0, mr_, txd
  );

  modport slave (
    input  soc, base, num, d7_d0,
    output eoc, a9_a0, mr_, txd
  );
endinterface

// File: rtl/mem_dump_tx.sv
// Reads a block of memory one location at a time and sends each {data, address}
// pair as an 18-bit LSB-first serial frame with start and stop bits.
module mem_dump_tx #(
  parameter int BIT_CLK = 8
) (
  input  logic          clock,
  input  logic          reset_,
  mem_dump_tx_if.slave  bus
);

  localparam int            CW       = (BIT_CLK > 1) ? $clog2(BIT_CLK) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CLK - 1);
  localparam logic [CW-1:0] BIT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    TXBIT,
    NEXT,
    END
  } state_t;

  state_t        state_q,   state_d;
  logic [9:0]    addr_q,    addr_d;
  logic [8:0]    count_q,   count_d;
  logic [17:0]   shreg_q,   shreg_d;
  logic [CW-1:0] bit_cyc_q, bit_cyc_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic          txd_q,     txd_d;
  logic          mr_q,      mr_d;
  logic          eoc_q,     eoc_d;

  assign bus.a9_a0 = addr_q;
  assign bus.txd   = txd_q;
  assign bus.mr_   = mr_q;
  assign bus.eoc   = eoc_q;

  // All outputs are registered so the serial line and read strobe never glitch.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      shreg_q   <= '0;
      bit_cyc_q <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
      mr_q      <= 1'b1;
      eoc_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      shreg_q   <= shreg_d;
      bit_cyc_q <= bit_cyc_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
      mr_q      <= mr_d;
      eoc_q     <= eoc_d;
    end
  end

  // bit_cnt counts the 18 payload bits plus the stop bit; the stop bit is timed in NEXT.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    shreg_d   = shreg_q;
    bit_cyc_d = bit_cyc_q;
    bit_cnt_d = bit_cnt_q;
    txd_d     = txd_q;
    mr_d      = mr_q;
    eoc_d     = eoc_q;

    case (state_q)
      IDLE: begin
        eoc_d = 1'b1;
        txd_d = 1'b1;
        mr_d  = 1'b1;
        if (bus.soc) begin
          addr_d  = bus.base;
          count_d = (bus.num == 8'd0) ? 9'd256 : {1'b0, bus.num};
          eoc_d   = 1'b0;
          mr_d    = 1'b0;
          state_d = RD1;
        end
      end

      RD1: begin
        state_d = RD2;
      end

      RD2: begin
        shreg_d   = {bus.d7_d0, addr_q};
        mr_d      = 1'b1;
        txd_d     = 1'b0;
        bit_cyc_d = BIT_LAST;
        bit_cnt_d = 5'd19;
        state_d   = TXBIT;
      end

      TXBIT: begin
        if (bit_cyc_q != '0) begin
          bit_cyc_d = bit_cyc_q - BIT_ONE;
        end else begin
          bit_cyc_d = BIT_LAST;
          bit_cnt_d = bit_cnt_q - 5'd1;
          if (bit_cnt_q == 5'd1) begin
            txd_d   = 1'b1;
            state_d = NEXT;
          end else begin
            txd_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end

      // End of the stop bit: either fetch the next location or finish the dump.
      NEXT: begin
        if (bit_cyc_q != '0) begin
          bit_cyc_d = bit_cyc_q - BIT_ONE;
        end else if (count_q > 9'd1) begin
          count_d = count_q - 9'd1;
          addr_d  = addr_q + 10'd1;
          mr_d    = 1'b0;
          state_d = RD1;
        end else begin
          eoc_d   = 1'b1;
          state_d = END;
        end
      end

      END: begin
        eoc_d = 1'b1;
        txd_d = 1'b1;
        mr_d  = 1'b1;
        if (!bus.soc) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        mr_d    = 1'b1;
        eoc_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/mem_dump_tx.md
MEM_DUMP_TX -- requirements
Module: mem_dump_tx

Interface
REQ-001 Parameter BIT_CLK, default 8: clock cycles per serial bit; matches the receiving end's 8-cycle bit time.
REQ-002 clock  in  1  single system clock; all state changes on its rising edge.
REQ-003 reset_  in  1  asynchronous, active-low reset.
REQ-004 soc  in  1  start-of-dump request, level, active high.
REQ-005 eoc  out  1  end-of-dump / ready flag, high when idle.
REQ-006 base  in  10  first memory address to dump, sampled only when soc is accepted.
REQ-007 num  in  8  number of locations to dump, sampled with base; 0 means 256.
REQ-008 a9_a0  out  10  memory address bus.
REQ-009 d7_d0  in  8  memory data bus.
REQ-010 mr_  out  1  memory read strobe, active low.
REQ-011 txd  out  1  serial line, idle high.

Function
REQ-012 Frame format SHALL be: start bit 0, then a0..a9, then d0..d7 (LSB first, 18 payload bits), then stop bit 1; every bit is held BIT_CLK cycles, giving 160 cycles per frame.
REQ-013 States: IDLE (eoc=1, wait soc=1), RD1, RD2, TXBIT, NEXT, END (eoc=1, wait soc=0); state register holds one-hot or binary encoding freely.
REQ-014 In IDLE at edge k with soc=1: latch base into a9_a0, latch num into a 9-bit counter (0 loads 256), drive eoc=0 and mr_=0, go RD1.
REQ-015 RD1 -> RD2 at edge k+1 with mr_ held 0 (two-cycle memory access).
REQ-016 At edge k+2: capture {d7_d0, a9_a0} into an 18-bit shift register, mr_=1, txd=0 (start bit), load bit-cycle counter with BIT_CLK-1 and bit counter with 19.
REQ-017 Each bit SHALL be held exactly BIT_CLK cycles; on each bit boundary txd takes shift-register bit 0 and the register shifts right, after 18 payload bits txd=1 for the stop bit.
REQ-018 Payload bit i SHALL start at edge k+10+8i; stop bit SHALL span edges k+154 to k+162.
REQ-019 At the end of the stop bit (edge k+162): if remaining count > 1, decrement count, increment a9_a0, drive mr_=0, go RD1; otherwise drive eoc=1, go END.
REQ-020 Frame-to-frame period SHALL be 162 cycles; txd SHALL stay 1 during RD1/RD2 between frames.
REQ-021 a9_a0 increment SHALL wrap modulo 1024 (0x3FF -> 0x000).
REQ-022 In END: eoc=1, txd=1, mr_=1; go IDLE only when soc=0 sampled; soc held high SHALL never start a second dump.
REQ-023 soc, base, num changes while eoc=0 SHALL be ignored.
REQ-024 mr_ SHALL be low only in RD1/RD2, exactly 2 cycles per location; never low while txd carries a frame bit.
REQ-025 d7_d0 SHALL be sampled only at the RD2 -> TXBIT edge.

Reset
REQ-026 reset_=0 SHALL immediately force txd=1, mr_=1, eoc=1, a9_a0=0, state IDLE, counters 0, regardless of clock.
REQ-027 Reset mid-frame SHALL abort the frame (line returns to idle high); no partial resumption after reset_ returns to 1.
REQ-028 After reset release, the first soc=1 sample in IDLE starts a dump per REQ-014.

Verification
REQ-029 base=0x2A5, num=1, memory[0x2A5]=0x3C -> mr_ low 2 cycles, txd bits 0,1010010101,00111100,1 at 8-cycle spacing, eoc rises at edge k+162.
REQ-030 base=0x3FF, num=2 -> frames for addresses 0x3FF then 0x000, second mr_ falls at edge k+162, eoc at k+324.
REQ-031 num=0, base=0x100 -> 256 frames, addresses 0x100..0x1FF, eoc after 256*162 cycles.
REQ-032 reset_ pulsed low during payload bit 7 -> txd=1, mr_=1, eoc=1 asynchronously; next soc starts a clean frame from new base.
REQ-033 soc held high through END for 500 cycles -> no new mr_ pulse, txd stays 1; soc low then high restarts.
REQ-034 Loopback into the team's 18-bit serial receiver with base=0x155, num=4 -> receiver writes identical address/data pairs to its memory.
